// File: rtl/stim_clock_sequencer_pkg.sv
// Shared types and helpers for the stimulus clock sequencer.
package stim_clock_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_REC = 2'd1,
    RUN_OFF = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned SAT_MAX_W = 64;

  // Double v within a w-bit field; once the top bit of the field is set the
  // result clamps to all-ones instead of shifting it out.
  function automatic logic [SAT_MAX_W-1:0] sat_double(
    input logic [SAT_MAX_W-1:0] v,
    input int unsigned          w
  );
    logic [SAT_MAX_W-1:0] mask;
    logic                 msb;
    mask = (w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << w) - SAT_MAX_W'(1));
    msb  = |(v & (SAT_MAX_W'(1) << (w - 1)));
    if (msb) return mask;
    return (v << 1) & mask;
  endfunction

endpackage

// File: rtl/stim_delay_chain.sv
// Registered inverter chain: stage 0 = ~i_d, stage k = ~stage k-1, one flop each.
module stim_delay_chain #(
  parameter int unsigned STAGES = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_d,
  output logic [STAGES-1:0] o_q
);

  logic [STAGES-1:0] r_q;

  // Shift the inverted value one stage per clock.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else begin
      r_q[0] <= ~i_d;
      for (int unsigned k = 1; k < STAGES; k++) begin
        r_q[k] <= ~r_q[k-1];
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/stim_clock_sequencer.sv
// Stimulus clock sequencer: divided clock, edge counting/timestamping,
// saturating doubling accumulator and a record-window FSM ending in a finish
// request. Define STIM_CLOCK_SEQUENCER_CHAIN_EN to build the inverted delay
// chain on gclk_chain; otherwise gclk_chain is tied to zero.
module stim_clock_sequencer
  import stim_clock_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned STAGES = 3,
  parameter int unsigned ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIV_W-1:0]  half_div,
  input  logic [CNT_W-1:0]  off_cnt,
  input  logic [CNT_W-1:0]  on_cnt,
  input  logic [CNT_W-1:0]  end_cnt,
  output logic              gclk,
  output logic [STAGES-1:0] gclk_chain,
  output logic [CNT_W-1:0]  edge_cnt,
  output logic [CNT_W-1:0]  t_stamp,
  output logic [ACC_W-1:0]  acc,
  output logic              edge_evt,
  output logic              rec_en,
  output logic              busy,
  output logic              done
);

  state_t             r_state, w_state_nxt;
  logic [DIV_W-1:0]   r_div, r_phase, w_div_in;
  logic [CNT_W-1:0]   r_off, r_on, r_end, r_timer, r_edge_cnt, r_t_stamp, w_edge_nxt;
  logic [ACC_W-1:0]   r_acc, w_acc_dbl;
  logic               r_gclk, r_evt, r_rec, r_busy, r_done;
  logic               w_start, w_run, w_toggle, w_rise;
  logic [STAGES-1:0]  w_chain;

  assign w_run      = (r_state == RUN_REC) || (r_state == RUN_OFF);
  assign w_start    = start && !w_run;
  assign w_toggle   = w_run && (r_phase == '0);
  assign w_rise     = w_toggle && !r_gclk;
  assign w_edge_nxt = r_edge_cnt + CNT_W'(1);
  assign w_div_in   = (half_div == '0) ? DIV_W'(1) : half_div;
  assign w_acc_dbl  = ACC_W'(sat_double(SAT_MAX_W'(r_acc), ACC_W));

  // Next state: thresholds are matched against the post-increment edge count,
  // end taking priority over off/on.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, DONE: if (start) w_state_nxt = RUN_REC;
      RUN_REC: if (w_rise) begin
        if (w_edge_nxt == r_end)      w_state_nxt = DONE;
        else if (w_edge_nxt == r_off) w_state_nxt = RUN_OFF;
      end
      RUN_OFF: if (w_rise) begin
        if (w_edge_nxt == r_end)      w_state_nxt = DONE;
        else if (w_edge_nxt == r_on)  w_state_nxt = RUN_REC;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register plus status flags registered from the next state, so they
  // change in the same cycle as the matching gclk rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rec   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rec   <= (w_state_nxt == RUN_REC);
      r_busy  <= (w_state_nxt == RUN_REC) || (w_state_nxt == RUN_OFF);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  // Divider, cycle timer, edge counter, timestamp and accumulator. gclk stops
  // toggling outside RUN_*, which freezes it high after the final rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div      <= '0;
      r_phase    <= '0;
      r_off      <= '0;
      r_on       <= '0;
      r_end      <= '0;
      r_timer    <= '0;
      r_edge_cnt <= '0;
      r_t_stamp  <= '0;
      r_acc      <= ACC_W'(1);
      r_gclk     <= 1'b0;
      r_evt      <= 1'b0;
    end else begin
      r_evt <= 1'b0;
      if (w_start) begin
        r_div      <= w_div_in;
        r_phase    <= w_div_in - DIV_W'(1);
        r_off      <= off_cnt;
        r_on       <= on_cnt;
        r_end      <= end_cnt;
        r_timer    <= '0;
        r_edge_cnt <= '0;
        r_t_stamp  <= '0;
        r_acc      <= ACC_W'(1);
        r_gclk     <= 1'b0;
      end else if (w_run) begin
        r_timer <= r_timer + CNT_W'(1);
        if (w_toggle) begin
          r_phase <= r_div - DIV_W'(1);
          r_gclk  <= ~r_gclk;
          if (w_rise) begin
            r_edge_cnt <= w_edge_nxt;
            r_t_stamp  <= r_timer + CNT_W'(1);
            r_acc      <= w_acc_dbl;
            r_evt      <= 1'b1;
          end
        end else begin
          r_phase <= r_phase - DIV_W'(1);
        end
      end
    end
  end

`ifdef STIM_CLOCK_SEQUENCER_CHAIN_EN
  stim_delay_chain #(.STAGES(STAGES)) u_chain (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (r_gclk),
    .o_q     (w_chain)
  );
`else
  assign w_chain = '0;
`endif

  assign gclk       = r_gclk;
  assign gclk_chain = w_chain;
  assign edge_cnt   = r_edge_cnt;
  assign t_stamp    = r_t_stamp;
  assign acc        = r_acc;
  assign edge_evt   = r_evt;
  assign rec_en     = r_rec;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_stim_clock_sequencer.sv
// Self-checking bench for stim_clock_sequencer: table of configurations with
// hand-derived final values, randomized runs against a closed-form model,
// plus reset and delay-chain sequences.
module tb_stim_clock_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  half_div = '0;
  logic [31:0] off_cnt = '0, on_cnt = '0, end_cnt = '0;

  logic        gclk, edge_evt, rec_en, busy, done;
  logic [2:0]  gclk_chain;
  logic [31:0] edge_cnt, t_stamp;
  logic [15:0] acc;

  logic        gclk4, edge_evt4, rec_en4, busy4, done4;
  logic [2:0]  gclk_chain4;
  logic [31:0] edge_cnt4, t_stamp4;
  logic [3:0]  acc4;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] hist = '0;

  always #5 clk = ~clk;

  // gclk as seen just before each rising edge; hist[j] = gclk of cycle n-1-j.
  always @(posedge clk) hist <= {hist[6:0], gclk};

  stim_clock_sequencer #(.CNT_W(32), .DIV_W(8), .STAGES(3), .ACC_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .half_div(half_div),
    .off_cnt(off_cnt), .on_cnt(on_cnt), .end_cnt(end_cnt),
    .gclk(gclk), .gclk_chain(gclk_chain), .edge_cnt(edge_cnt), .t_stamp(t_stamp),
    .acc(acc), .edge_evt(edge_evt), .rec_en(rec_en), .busy(busy), .done(done)
  );

  stim_clock_sequencer #(.CNT_W(32), .DIV_W(8), .STAGES(3), .ACC_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .half_div(half_div),
    .off_cnt(off_cnt), .on_cnt(on_cnt), .end_cnt(end_cnt),
    .gclk(gclk4), .gclk_chain(gclk_chain4), .edge_cnt(edge_cnt4), .t_stamp(t_stamp4),
    .acc(acc4), .edge_evt(edge_evt4), .rec_en(rec_en4), .busy(busy4), .done(done4)
  );

  typedef struct {
    logic            gclk, evt, rec, busy, done;
    longint unsigned ec, ts, acc, acc4;
  } exp_t;

  typedef struct {
    int              hd, off, on, en;
    int              dc;
    longint unsigned ec, ts, acc, acc4;
  } vec_t;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected outputs n cycles after the start edge, from the timing rules:
  // rises at n = d+1 + 2d*j, t_stamp = (2k-1)*d, acc = 2^k clamped.
  function automatic exp_t model(input int n, input int d, input int off, input int on, input int en);
    exp_t e;
    int   k, dc;
    bit   rec;
    dc = d + 1 + 2 * d * (en - 1);
    k  = (n >= d + 1) ? (n - 1 - d) / (2 * d) + 1 : 0;
    if (k >= en) begin
      k = en; e.done = 1'b1; e.busy = 1'b0; e.rec = 1'b0; e.gclk = 1'b1;
      e.evt = (n == dc);
    end else begin
      e.done = 1'b0; e.busy = 1'b1;
      e.gclk = (((n - 1) / d) % 2 == 1);
      e.evt  = (n >= d + 1) && ((n - 1 - d) % (2 * d) == 0);
      rec = 1'b1;
      for (int i = 1; i <= k; i++) begin
        if (rec && i == off)       rec = 1'b0;
        else if (!rec && i == on)  rec = 1'b1;
      end
      e.rec = rec;
    end
    e.ec   = longint'(k);
    e.ts   = (k == 0) ? 0 : longint'((2 * k - 1) * d);
    e.acc  = (k >= 16) ? 65535 : (64'd1 << k);
    e.acc4 = (k >= 4) ? 15 : (64'd1 << k);
    return e;
  endfunction

  // Start a run and compare every cycle until three cycles past the finish.
  // A start pulse is injected at cycle `inject` (0 = none) and must be ignored.
  task automatic run_cfg(input int hd, input int off, input int on, input int en,
                         input int inject, output int done_cyc);
    int   d, dc;
    exp_t e;
    d  = (hd == 0) ? 1 : hd;
    dc = d + 1 + 2 * d * (en - 1);
    done_cyc = 0;
    @(negedge clk);
    half_div = 8'(hd); off_cnt = 32'(off); on_cnt = 32'(on); end_cnt = 32'(en);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= dc + 3; n++) begin
      @(negedge clk);
      e = model(n, d, off, on, en);
      chk($sformatf("gclk@%0d", n),     gclk,     e.gclk);
      chk($sformatf("edge_cnt@%0d", n), edge_cnt, e.ec);
      chk($sformatf("t_stamp@%0d", n),  t_stamp,  e.ts);
      chk($sformatf("acc@%0d", n),      acc,      e.acc);
      chk($sformatf("acc4@%0d", n),     acc4,     e.acc4);
      chk($sformatf("edge_evt@%0d", n), edge_evt, e.evt);
      chk($sformatf("rec_en@%0d", n),   rec_en,   e.rec);
      chk($sformatf("busy@%0d", n),     busy,     e.busy);
      chk($sformatf("done@%0d", n),     done,     e.done);
      for (int k = 0; k < 3; k++) begin
`ifdef STIM_CLOCK_SEQUENCER_CHAIN_EN
        chk($sformatf("chain%0d@%0d", k, n), gclk_chain[k], (k % 2 == 0) ? ~hist[k] : hist[k]);
`else
        chk($sformatf("chain%0d@%0d", k, n), gclk_chain[k], 1'b0);
`endif
      end
      if (done && done_cyc == 0) done_cyc = n;
      if (n == inject) begin
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    end
  endtask

  vec_t tbl[6];

  initial begin
    int dcyc, hd, off, on, en, d, dc, inj, waited;

    tbl[0] = '{hd:5, off:100, on:200, en:4,  dc:36, ec:4,  ts:35, acc:16,   acc4:15};
    tbl[1] = '{hd:1, off:3,   on:6,   en:10, dc:20, ec:10, ts:19, acc:1024, acc4:15};
    tbl[2] = '{hd:0, off:3,   on:3,   en:3,  dc:6,  ec:3,  ts:5,  acc:8,    acc4:8};
    tbl[3] = '{hd:2, off:1,   on:2,   en:3,  dc:11, ec:3,  ts:10, acc:8,    acc4:8};
    tbl[4] = '{hd:3, off:0,   on:0,   en:2,  dc:10, ec:2,  ts:9,  acc:4,    acc4:4};
    tbl[5] = '{hd:1, off:50,  on:60,  en:5,  dc:10, ec:5,  ts:9,  acc:32,   acc4:15};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gclk", gclk, 0);       chk("rst_chain", gclk_chain, 0);
    chk("rst_edge_cnt", edge_cnt, 0); chk("rst_t_stamp", t_stamp, 0);
    chk("rst_acc", acc, 1);         chk("rst_acc4", acc4, 1);
    chk("rst_evt", edge_evt, 0);    chk("rst_rec", rec_en, 0);
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);

    // Table-driven configurations with hand-derived final values.
    for (int i = 0; i < 6; i++) begin
      run_cfg(tbl[i].hd, tbl[i].off, tbl[i].on, tbl[i].en, (i == 2) ? 3 : 0, dcyc);
      chk($sformatf("tbl%0d_done_cycle", i), longint'(dcyc), longint'(tbl[i].dc));
      chk($sformatf("tbl%0d_edge_cnt", i), edge_cnt, tbl[i].ec);
      chk($sformatf("tbl%0d_t_stamp", i),  t_stamp,  tbl[i].ts);
      chk($sformatf("tbl%0d_acc", i),      acc,      tbl[i].acc);
      chk($sformatf("tbl%0d_acc4", i),     acc4,     tbl[i].acc4);
      chk($sformatf("tbl%0d_gclk_frozen", i), gclk, 1);
    end

    // Randomized configurations with an ignored mid-run start pulse.
    for (int r = 0; r < 8; r++) begin
      hd  = int'($urandom_range(0, 4));
      en  = int'($urandom_range(1, 8));
      off = int'($urandom_range(0, 10));
      on  = int'($urandom_range(0, 10));
      d   = (hd == 0) ? 1 : hd;
      dc  = d + 1 + 2 * d * (en - 1);
      inj = int'($urandom_range(1, dc - 1));
      run_cfg(hd, off, on, en, inj, dcyc);
      chk($sformatf("rnd%0d_done_cycle", r), longint'(dcyc), longint'(dc));
    end

    // Reset mid-run after 7 edges.
    @(negedge clk);
    half_div = 8'd2; off_cnt = 32'd100; on_cnt = 32'd200; end_cnt = 32'd100;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    waited = 0;
    while (edge_cnt != 32'd7 && waited < 200) begin
      @(negedge clk); waited++;
    end
    chk("mid_reach_7_edges", edge_cnt, 7);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_gclk", gclk, 0);        chk("mid_edge_cnt", edge_cnt, 0);
    chk("mid_t_stamp", t_stamp, 0);  chk("mid_acc", acc, 1);
    chk("mid_evt", edge_evt, 0);     chk("mid_rec", rec_en, 0);
    chk("mid_busy", busy, 0);        chk("mid_done", done, 0);
    chk("mid_chain", gclk_chain, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("mid_idle_evt%0d", c), edge_evt, 0);
      chk($sformatf("mid_idle_busy%0d", c), busy, 0);
      chk($sformatf("mid_idle_gclk%0d", c), gclk, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
